// File: rtl/rc4_keystream.sv
// rc4_keystream
// RC4 keystream generator. The password is accepted byte-serially, the
// S-box is initialised and key-scheduled (KSA), and keystream bytes are
// then produced one per cycle (PRGA) over a valid/ready handshake.
//
// Parameters:
//   MAX_KEY   maximum stored password length in bytes (1..256)
//   DROP_N    keystream bytes discarded after KSA (only with RC4_DROP_EN)
//
// Optional build macro:
//   RC4_DROP_EN  when defined, the generator silently runs DROP_N PRGA
//                steps after the KSA before raising init_done.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous active-low reset
//   password   in   [7:0] key byte
//   key_valid  in   password byte present this cycle
//   key_last   in   marks the final key byte (with key_valid)
//   init_done  out  KSA complete, generator in GEN state
//   ks_byte    out  [7:0] keystream byte
//   ks_valid   out  ks_byte valid
//   ks_ready   in   consumer accepts ks_byte
module rc4_keystream #(
    parameter int unsigned MAX_KEY = 16,
    parameter int unsigned DROP_N  = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] password,
    input  logic       key_valid,
    input  logic       key_last,
    output logic       init_done,
    output logic [7:0] ks_byte,
    output logic       ks_valid,
    input  logic       ks_ready
);

    // Length counter must reach MAX_KEY itself; key index only 0..MAX_KEY-1.
    localparam int LW = $clog2(MAX_KEY + 1);
    localparam int KW = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;

    typedef enum logic [1:0] {
        LOAD,
        INIT,
        KSA,
        GEN
    } state_e;

    state_e         state_q;
    logic [7:0]     sBox_q [256];
    logic [7:0]     key_q  [MAX_KEY];
    logic [7:0]     i_q;
    logic [7:0]     j_q;
    logic [LW-1:0]  len_q;
    logic [KW-1:0]  kIdx_q;
    logic           initDone_q;
    logic           ksValid_q;
    logic [7:0]     ksByte_q;

    // KSA datapath: K index tracks i mod len without a divider.
    logic [7:0] ksaJ_d;
    logic       kIdxLast;
    assign ksaJ_d   = j_q + sBox_q[i_q] + key_q[kIdx_q];
    assign kIdxLast = (LW'(kIdx_q) == (len_q - LW'(1)));

    // PRGA datapath. The output byte is read from the post-swap S-box, so
    // when t hits one of the two swapped slots the other old value is used.
    logic [7:0] genI_d;
    logic [7:0] genJ_d;
    logic [7:0] genSi;
    logic [7:0] genSj;
    logic [7:0] genT;
    logic [7:0] genByte_d;
    assign genI_d    = i_q + 8'd1;
    assign genSi     = sBox_q[genI_d];
    assign genJ_d    = j_q + genSi;
    assign genSj     = sBox_q[genJ_d];
    assign genT      = genSi + genSj;
    assign genByte_d = (genT == genI_d) ? genSj :
                       (genT == genJ_d) ? genSi : sBox_q[genT];

    // genAdvance moves i/j and swaps; genEmit also presents a new byte.
    logic genEmit;
    logic genAdvance;

`ifdef RC4_DROP_EN
    logic [31:0] dropCnt_q;
    logic        genDrop;
    assign genDrop    = (dropCnt_q != 32'd0);
    assign genEmit    = !genDrop && (!ksValid_q || ks_ready);
    assign genAdvance = genDrop || genEmit;
`else
    logic unusedDropN;
    assign unusedDropN = (DROP_N != 0);
    assign genEmit     = !ksValid_q || ks_ready;
    assign genAdvance  = genEmit;
`endif

    // Control FSM plus S-box/key storage. Arrays are not reset; their
    // contents are rebuilt by LOAD/INIT before they are ever read.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LOAD;
            len_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            kIdx_q     <= '0;
            initDone_q <= 1'b0;
            ksValid_q  <= 1'b0;
            ksByte_q   <= '0;
`ifdef RC4_DROP_EN
            dropCnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (key_valid) begin
                        if (len_q < LW'(MAX_KEY)) begin
                            key_q[len_q[KW-1:0]] <= password;
                            len_q                <= len_q + LW'(1);
                        end
                        if (key_last) begin
                            state_q <= INIT;
                            i_q     <= '0;
                        end
                    end
                end

                INIT: begin
                    sBox_q[i_q] <= i_q;
                    i_q         <= i_q + 8'd1;
                    if (i_q == 8'hFF) begin
                        state_q <= KSA;
                        j_q     <= '0;
                        kIdx_q  <= '0;
                    end
                end

                KSA: begin
                    // When i == jn both writes carry the same value.
                    sBox_q[i_q]    <= sBox_q[ksaJ_d];
                    sBox_q[ksaJ_d] <= sBox_q[i_q];
                    j_q            <= ksaJ_d;
                    i_q            <= i_q + 8'd1;
                    kIdx_q         <= kIdxLast ? '0 : kIdx_q + KW'(1);
                    if (i_q == 8'hFF) begin
                        state_q <= GEN;
                        i_q     <= '0;
                        j_q     <= '0;
`ifdef RC4_DROP_EN
                        dropCnt_q  <= DROP_N;
                        initDone_q <= (DROP_N == 0);
`else
                        initDone_q <= 1'b1;
`endif
                    end
                end

                GEN: begin
                    if (key_valid) begin
                        // Rekey: this byte becomes K[0] of the new password.
                        key_q[0]   <= password;
                        len_q      <= LW'(1);
                        initDone_q <= 1'b0;
                        ksValid_q  <= 1'b0;
                        i_q        <= '0;
                        j_q        <= '0;
                        state_q    <= key_last ? INIT : LOAD;
`ifdef RC4_DROP_EN
                        dropCnt_q  <= '0;
`endif
                    end else begin
                        if (genAdvance) begin
                            sBox_q[genI_d] <= genSj;
                            sBox_q[genJ_d] <= genSi;
                            i_q            <= genI_d;
                            j_q            <= genJ_d;
                        end
                        if (genEmit) begin
                            ksByte_q  <= genByte_d;
                            ksValid_q <= 1'b1;
                        end
`ifdef RC4_DROP_EN
                        if (genDrop) begin
                            dropCnt_q <= dropCnt_q - 32'd1;
                            if (dropCnt_q == 32'd1) begin
                                initDone_q <= 1'b1;
                            end
                        end
`endif
                    end
                end

                default: state_q <= LOAD;
            endcase
        end
    end

    assign init_done = initDone_q;
    assign ks_valid  = ksValid_q;
    assign ks_byte   = ksByte_q;

endmodule
